// File: rtl/ivector_driver.sv
// Client end of the IVector request/indication pair: bursts self-describing vectors
// and checks the echoes. Optional watchdog when IVECTOR_DRV_TIMEOUT_EN is defined.
module ivector_driver #(
  parameter int WIDTH   = 704,
  parameter int CNT_W   = 16,
  parameter int MAX_OUT = 4,
  parameter int TO_W    = 12
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start__ENA,
  input  logic [CNT_W-1:0]  start_count,
  output logic              start__RDY,
  output logic              say__ENA,
  output logic [WIDTH-1:0]  say_v,
  input  logic              say__RDY,
  input  logic              heard__ENA,
  input  logic [WIDTH-1:0]  heard_v,
  output logic              heard__RDY,
  output logic              done,
  output logic [CNT_W-1:0]  err_count,
  output logic              timeout
);

  localparam int WORDS = WIDTH / 32;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] sent_reg;
  logic [CNT_W-1:0] recv_reg;
  logic [CNT_W-1:0] n_reg;
  logic [CNT_W-1:0] err_reg;
  logic             done_reg;

  logic [CNT_W-1:0] in_flight;
  logic [15:0]      sent_seq;
  logic [15:0]      recv_seq;
  logic [WIDTH-1:0] expect_v;
  logic             say_fire;
  logic             heard_acc;
  logic             heard_expected;
  logic             err_inc;

  assign in_flight = sent_reg - recv_reg;
  assign sent_seq  = 16'(sent_reg);
  assign recv_seq  = 16'(recv_reg);

  // Word k of pattern(s) is {s[15:0], k[15:0]}; the expected echo is pattern(recv).
  for (genvar gi = 0; gi < WORDS; gi++) begin : g_pattern
    assign say_v[32*gi +: 32]    = {sent_seq, 16'(gi)};
    assign expect_v[32*gi +: 32] = {recv_seq, 16'(gi)};
  end

  assign start__RDY = (state_reg == IDLE) || (state_reg == DONE);
  assign heard__RDY = (state_reg == RUN) || (state_reg == DRAIN);
  assign say_fire   = (state_reg == RUN) && (sent_reg < n_reg) &&
                      (in_flight < CNT_W'(MAX_OUT)) && say__RDY;
  assign say__ENA   = say_fire;

  assign heard_acc      = heard__ENA && heard__RDY;
  assign heard_expected = heard_acc && (in_flight != '0);
  // A response with nothing outstanding is an error even if a say fires this cycle.
  assign err_inc        = heard_acc && ((in_flight == '0) || (heard_v != expect_v));

  assign done      = done_reg;
  assign err_count = err_reg;

`ifdef IVECTOR_DRV_TIMEOUT_EN
  logic [TO_W-1:0] wd_reg;
  logic            timeout_reg;
  assign timeout = timeout_reg;
`else
  logic [TO_W-1:0] wd_unused;
  assign wd_unused = '0;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      sent_reg  <= '0;
      recv_reg  <= '0;
      n_reg     <= '0;
      err_reg   <= '0;
      done_reg  <= 1'b0;
`ifdef IVECTOR_DRV_TIMEOUT_EN
      wd_reg      <= '0;
      timeout_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start__ENA) begin
            n_reg    <= start_count;
            sent_reg <= '0;
            recv_reg <= '0;
            err_reg  <= '0;
`ifdef IVECTOR_DRV_TIMEOUT_EN
            wd_reg      <= '0;
            timeout_reg <= 1'b0;
`endif
            if (start_count == '0) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= RUN;
              done_reg  <= 1'b0;
            end
          end
        end
        RUN, DRAIN: begin
          if (say_fire)
            sent_reg <= sent_reg + CNT_W'(1);
          if (heard_expected)
            recv_reg <= recv_reg + CNT_W'(1);
          if (err_inc && (err_reg != '1))
            err_reg <= err_reg + CNT_W'(1);

          if (state_reg == RUN && say_fire && (sent_reg + CNT_W'(1) == n_reg))
            state_reg <= DRAIN;
          if (state_reg == DRAIN && heard_expected && (recv_reg + CNT_W'(1) == n_reg)) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end

`ifdef IVECTOR_DRV_TIMEOUT_EN
          if (heard_acc)
            wd_reg <= '0;
          else if (in_flight != '0)
            wd_reg <= wd_reg + TO_W'(1);
          // Expiry wins over any transition decided above.
          if (!heard_acc && (in_flight != '0) && (wd_reg == '1)) begin
            state_reg   <= DONE;
            done_reg    <= 1'b1;
            timeout_reg <= 1'b1;
          end
`endif
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
